c2sif_initiator: RTL and testbench
==================================

Name: c2sif_initiator

Overview:
- Synthesizable requester for the c2sif four-phase req/ack handshake; the initiating end that bench responders and DUT-side c2sif targets answer.
- Accepts commands on a valid/ready port, drives req/id/fn/wdata, waits for ack, captures ret/rdata, then completes the return-to-zero phase.
- Reports completion or timeout on a single-cycle response strobe.
- Sits between a test-sequencer or CPU-side command source and any number of c2sif targets sharing the id bus.

Parameters:
- ID_W, 8, width of target id field
- DATA_W, 32, width of write and read data
- SYNC_STAGES, 2, flops on incoming ack (min 2); responders may be unclocked
- TIMEOUT, 1023, cycles allowed per handshake phase before abort (must be >= 1)

Ports:
- clk  input  1  sole clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block idle and accepting
- cmd_id  input  ID_W  target id
- cmd_fn  input  1  0 = write, 1 = read
- cmd_wdata  input  DATA_W  write data (ignored for read)
- req  output  1  c2sif request
- id  output  ID_W  c2sif target id
- fn  output  1  c2sif function
- wdata  output  DATA_W  c2sif write data
- ack  input  1  c2sif acknowledge, asynchronous to clk
- ret  input  1  c2sif status from target (0 = ok)
- rdata  input  DATA_W  c2sif read data from target
- rsp_valid  output  1  one-cycle completion strobe
- rsp_ret  output  1  captured ret; forced 1 on timeout
- rsp_rdata  output  DATA_W  captured rdata (reads); 0 for writes and timeouts
- rsp_timeout  output  1  handshake aborted by timeout

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE, timeout counter = 0, ack synchronizer flops = 0.
- ack_s is ack after SYNC_STAGES flops. All handshake decisions use ack_s only.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch cmd_id/cmd_fn/cmd_wdata into id/fn/wdata, then go to SETUP; cmd_ready drops the next cycle.
  - SETUP: one cycle with id/fn/wdata stable and req = 0, giving the target setup time. Then go to REQ.
  - REQ: req = 1.
    - On ack_s = 1: capture ret and rdata (rdata only if fn = 1, else 0), set req = 0, go to REL.
    - If the counter reaches TIMEOUT first: set req = 0, set the timeout flag, go to REL.
  - REL: req = 0; wait for ack_s = 0.
    - If the counter reaches TIMEOUT in REL, set the timeout flag and go to RSP anyway.
    - Otherwise go to RSP when ack_s = 0.
  - RSP: rsp_valid = 1 for exactly one cycle, with rsp_ret/rsp_rdata/rsp_timeout valid that cycle. Go to IDLE. cmd_ready = 1 the following cycle.
- Timeout counter:
  - Clears on entry to REQ and to REL; increments each cycle in those states.
  - Saturates, never wraps.
  - On timeout: rsp_ret = 1, rsp_rdata = 0, rsp_timeout = 1.
- id/fn/wdata hold their latched values from SETUP through RSP. They are not cleared afterwards; only the next accepted command changes them.
- cmd_valid while cmd_ready = 0 is ignored. There is no queue, and the source must hold the command until accepted.
- ack_s already 1 on entry to REQ (stale ack from a prior abort): treated as an acknowledge, so a misbehaving target still completes.
- Latency, ideal target (ack rises the cycle after req): cmd accept → rsp_valid = 2 + 2·SYNC_STAGES + 2 cycles minimum (8 with defaults).
- Asynchronous reset mid-transaction: req drops immediately (combinationally via reset), no rsp_valid is issued, and the block returns to IDLE.
- rsp_valid never asserts in the same cycle as cmd_ready.

Test Plan:
- Write: cmd id=3, fn=0, wdata=0x0000_0001; target acks after 4 cycles with ret=0 → req rises 1 cycle after accept; rsp_valid single pulse; rsp_ret=0, rsp_rdata=0, rsp_timeout=0.
- Read: id=5, fn=1; target drives rdata=0xDEAD_BEEF, ret=0 with ack → rsp_rdata=0xDEAD_BEEF; req low before rsp_valid.
- Back-to-back: cmd_valid held high with two writes → second accepted only in the cycle after RSP; req has a clean low gap ≥ 1 cycle between transactions; exactly 2 rsp_valid pulses.
- Timeout: no target responds (ack=0), TIMEOUT=15 → req high for 15 cycles then low; rsp_timeout=1, rsp_ret=1, rsp_rdata=0; block is accepting again.
- Stuck ack: ack rises and never falls, TIMEOUT=15 → REL timeout; rsp_timeout=1 with ret captured value overridden to 1. The next command completes immediately on the stale ack.
- Reset mid-REQ: assert rst while req=1 → req=0 asynchronously, no rsp_valid; after release cmd_ready=1 and a fresh write completes normally.

Source files
------------

// File: rtl/c2sif_initiator.sv
// c2sif requester: takes one command at a time from a valid/ready port and runs
// the four-phase req/ack handshake against a synchronised ack, with per-phase timeout.
module c2sif_initiator #(
   parameter int ID_W        = 8,
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ID_W-1:0]   cmd_id,
   input  logic              cmd_fn,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              req,
   output logic [ID_W-1:0]   id,
   output logic              fn,
   output logic [DATA_W-1:0] wdata,
   input  logic              ack,
   input  logic              ret,
   input  logic [DATA_W-1:0] rdata,
   output logic              rsp_valid,
   output logic              rsp_ret,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_REQ,
      S_REL,
      S_RSP
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic [ID_W-1:0]        r_id;
   logic                   r_fn;
   logic [DATA_W-1:0]      r_wdata;
   logic                   r_req;
   logic                   r_cap_ret;
   logic [DATA_W-1:0]      r_cap_rdata;
   logic                   r_to;
   logic                   r_rsp_valid;
   logic                   r_rsp_ret;
   logic [DATA_W-1:0]      r_rsp_rdata;
   logic                   r_rsp_timeout;

   logic w_ack_s;
   logic w_cnt_last;
   logic w_cnt_clr;
   logic w_accept;
   logic w_cap;
   logic w_req_to;
   logic w_rel_to;
   logic w_to_final;

   assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_cnt_clr  = (w_state_nxt != r_state) &&
                       ((w_state_nxt == S_REQ) || (w_state_nxt == S_REL));
   assign w_to_final = r_to | w_rel_to;

   // ack comes from an unclocked or foreign-clock target; every decision uses w_ack_s
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_cap       = 1'b0;
      w_req_to    = 1'b0;
      w_rel_to    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            // a stale ack still high on entry counts as the acknowledge
            if (w_ack_s) begin
               w_cap       = 1'b1;
               w_state_nxt = S_REL;
            end else if (w_cnt_last) begin
               w_req_to    = 1'b1;
               w_state_nxt = S_REL;
            end
         end
         S_REL: begin
            if (!w_ack_s) begin
               w_state_nxt = S_RSP;
            end else if (w_cnt_last) begin
               w_rel_to    = 1'b1;
               w_state_nxt = S_RSP;
            end
         end
         S_RSP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // phase counter: restarts on entry to REQ and REL, sticks at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_cnt_clr) begin
         r_cnt <= '0;
      end else if (((r_state == S_REQ) || (r_state == S_REL)) && (r_cnt != CNT_SAT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id          <= '0;
         r_fn          <= 1'b0;
         r_wdata       <= '0;
         r_req         <= 1'b0;
         r_cap_ret     <= 1'b0;
         r_cap_rdata   <= '0;
         r_to          <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_ret     <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_id    <= cmd_id;
            r_fn    <= cmd_fn;
            r_wdata <= cmd_wdata;
            r_to    <= 1'b0;
         end
         if (w_cap) begin
            r_cap_ret   <= ret;
            r_cap_rdata <= r_fn ? rdata : '0;
         end
         if (w_req_to) begin
            r_to <= 1'b1;
         end
         r_req       <= (w_state_nxt == S_REQ);
         r_rsp_valid <= (w_state_nxt == S_RSP);
         // response fields are only non-zero during the single RSP cycle
         if (w_state_nxt == S_RSP) begin
            r_rsp_ret     <= w_to_final | r_cap_ret;
            r_rsp_rdata   <= w_to_final ? '0 : r_cap_rdata;
            r_rsp_timeout <= w_to_final;
         end else begin
            r_rsp_ret     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
         end
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign req         = r_req;
   assign id          = r_id;
   assign fn          = r_fn;
   assign wdata       = r_wdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_ret     = r_rsp_ret;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_c2sif_initiator.sv
// Bench for c2sif_initiator: responder target, timestamp-based reference model,
// per-cycle comparison plus directed literal checks and randomized traffic.
module tb_c2sif_initiator;

   localparam int IDW = 8;
   localparam int DW  = 32;
   localparam int SS  = 2;
   localparam int TMO = 15;

   localparam int R_NORMAL = 0;
   localparam int R_SILENT = 1;
   localparam int R_STUCK  = 2;

   logic            clk;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [IDW-1:0]  cmd_id;
   logic            cmd_fn;
   logic [DW-1:0]   cmd_wdata;
   logic            req;
   logic [IDW-1:0]  id;
   logic            fn;
   logic [DW-1:0]   wdata;
   logic            ack;
   logic            ret;
   logic [DW-1:0]   rdata;
   logic            rsp_valid;
   logic            rsp_ret;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_timeout;

   int n_err = 0;
   int n_chk = 0;

   c2sif_initiator #(
      .ID_W(IDW), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
      .cmd_fn(cmd_fn), .cmd_wdata(cmd_wdata),
      .req(req), .id(id), .fn(fn), .wdata(wdata),
      .ack(ack), .ret(ret), .rdata(rdata),
      .rsp_valid(rsp_valid), .rsp_ret(rsp_ret), .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- responder target ----------------
   int            rmode   = R_NORMAL;
   int            dly_up  = 1;
   int            dly_dn  = 1;
   logic          cfg_ret = 1'b0;
   logic [DW-1:0] cfg_rd  = '0;
   int            cu = 0;
   int            cd = 0;

   always @(negedge clk) begin
      if (rst) begin
         ack = 1'b0; ret = 1'b0; cu = 0; cd = 0;
      end else begin
         case (rmode)
            R_SILENT: ack = 1'b0;
            R_STUCK: begin
               if (req && !ack) begin
                  ack = 1'b1; ret = cfg_ret; rdata = cfg_rd;
               end
            end
            default: begin
               if (req && !ack) begin
                  cu++; cd = 0;
                  if (cu >= dly_up) begin
                     ack = 1'b1; ret = cfg_ret; rdata = cfg_rd;
                  end
               end else if (!req && ack) begin
                  cd++; cu = 0;
                  if (cd >= dly_dn) ack = 1'b0;
               end else begin
                  cu = 0; cd = 0;
               end
            end
         endcase
      end
      if (!ack) rdata = $urandom;
   end

   // ---------------- reference model ----------------
   // One transaction is described by the edge numbers at which it was accepted,
   // at which req fell, and at which the release phase ended.
   bit             ack_q[$];
   int             mn = 0;
   bit             m_busy = 0;
   int             t_acc = 0, t_fall = -1, t_rel = -1;
   bit             m_to = 0, m_ret = 0, m_fn = 0;
   logic [DW-1:0]  m_rd = '0, m_wd = '0;
   logic [IDW-1:0] m_id = '0;
   logic           exp_ready = 1'b1, exp_req = 1'b0, exp_rv = 1'b0;
   logic           exp_rret = 1'b0, exp_rto = 1'b0;
   logic [DW-1:0]  exp_rrd = '0;

   always @(posedge clk or posedge rst) begin
      bit ack_s;
      int k;
      if (rst) begin
         ack_q.delete();
         for (int i = 0; i < SS; i++) ack_q.push_back(1'b0);
         mn = 0; m_busy = 0; t_fall = -1; t_rel = -1; m_to = 0; m_ret = 0;
         m_rd = '0; m_id = '0; m_fn = 0; m_wd = '0;
      end else begin
         mn++;
         ack_q.push_front(ack);
         ack_s = ack_q[SS];
         void'(ack_q.pop_back());
         if (m_busy) begin
            if (t_rel >= 0) begin
               if (mn == t_rel + 1) m_busy = 0;
            end else if (t_fall >= 0) begin
               k = mn - t_fall - 1;
               if (!ack_s) t_rel = mn;
               else if (k == TMO - 1) begin m_to = 1; t_rel = mn; end
            end else if (mn >= t_acc + 2) begin
               k = mn - t_acc - 2;
               if (ack_s) begin
                  m_ret = ret; m_rd = m_fn ? rdata : '0; t_fall = mn;
               end else if (k == TMO - 1) begin
                  m_to = 1; t_fall = mn;
               end
            end
         end else if (cmd_valid) begin
            m_busy = 1; t_acc = mn; t_fall = -1; t_rel = -1; m_to = 0;
            m_id = cmd_id; m_fn = cmd_fn; m_wd = cmd_wdata;
         end
      end
      exp_ready = !m_busy;
      exp_req   = m_busy && (t_fall < 0) && (mn >= t_acc + 1);
      exp_rv    = m_busy && (t_rel >= 0) && (mn == t_rel);
      exp_rto   = exp_rv && m_to;
      exp_rret  = exp_rv && (m_to || m_ret);
      exp_rrd   = (exp_rv && !m_to) ? m_rd : '0;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("req", req, exp_req);
      chk("id", id, m_id);
      chk("fn", fn, m_fn);
      chk("wdata", wdata, m_wd);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_ret", rsp_ret, exp_rret);
      chk("rsp_rdata", rsp_rdata, exp_rrd);
      chk("rsp_timeout", rsp_timeout, exp_rto);
   end

   // ---------------- stimulus ----------------
   task automatic run_cmd(input logic [IDW-1:0] i_id, input logic i_fn, input logic [DW-1:0] i_wd,
                          output int lat, output int req_hi, output logic o_ret,
                          output logic [DW-1:0] o_rd, output logic o_to, output bit ok);
      int w;
      ok = 1; lat = 0; req_hi = 0; o_ret = 0; o_rd = '0; o_to = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_id = i_id; cmd_fn = i_fn; cmd_wdata = i_wd;
      w = 0;
      while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
      if (!cmd_ready) begin cmd_valid = 1'b0; ok = 0; return; end
      @(negedge clk);
      cmd_valid = 1'b0;
      while (!rsp_valid && lat < 200) begin
         if (req) req_hi++;
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin ok = 0; return; end
      o_ret = rsp_ret; o_rd = rsp_rdata; o_to = rsp_timeout;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int            lat, rh, w, pulses, i_rsp1, i_acc2, drop_at;
      logic          o_ret, o_to;
      logic [DW-1:0] o_rd;
      bit            ok, acc2;

      rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_fn = 1'b0; cmd_wdata = '0;
      ack = 1'b0; ret = 1'b0; rdata = '0;
      @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1'b1);
      chk("reset_req", req, 1'b0);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // write, target acks after 4 cycles
      rmode = R_NORMAL; dly_up = 4; dly_dn = 1; cfg_ret = 1'b0; cfg_rd = 32'h1234_5678;
      run_cmd(8'd3, 1'b0, 32'h0000_0001, lat, rh, o_ret, o_rd, o_to, ok);
      chk("wr_done", ok, 1'b1);
      chk("wr_latency", lat, 10);
      chk("wr_req_cycles", rh, 6);
      chk("wr_ret", o_ret, 1'b0);
      chk("wr_rdata", o_rd, 32'h0);
      chk("wr_timeout", o_to, 1'b0);

      // read
      cfg_rd = 32'hDEAD_BEEF;
      run_cmd(8'd5, 1'b1, 32'hFFFF_0000, lat, rh, o_ret, o_rd, o_to, ok);
      chk("rd_done", ok, 1'b1);
      chk("rd_latency", lat, 10);
      chk("rd_rdata", o_rd, 32'hDEAD_BEEF);
      chk("rd_ret", o_ret, 1'b0);

      // back-to-back with cmd_valid held
      dly_up = 2; dly_dn = 1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_id = 8'h11; cmd_fn = 1'b0; cmd_wdata = 32'hA5A5_0001;
      w = 0;
      while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      cmd_id = 8'h22; cmd_wdata = 32'hA5A5_0002;
      pulses = 0; i_rsp1 = -1; i_acc2 = -1; drop_at = -1; acc2 = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (i == drop_at) cmd_valid = 1'b0;
         if (rsp_valid) begin
            pulses++;
            if (i_rsp1 < 0) i_rsp1 = i;
         end
         if (cmd_ready && cmd_valid && !acc2) begin acc2 = 1; i_acc2 = i; drop_at = i + 1; end
      end
      cmd_valid = 1'b0;
      chk("b2b_pulses", pulses, 2);
      chk("b2b_second_accept", i_acc2, i_rsp1 + 1);

      // timeout: nobody answers
      rmode = R_SILENT;
      run_cmd(8'd7, 1'b1, 32'h0, lat, rh, o_ret, o_rd, o_to, ok);
      chk("to_done", ok, 1'b1);
      chk("to_req_cycles", rh, TMO);
      chk("to_latency", lat, 17);
      chk("to_flag", o_to, 1'b1);
      chk("to_ret", o_ret, 1'b1);
      chk("to_rdata", o_rd, 32'h0);
      @(negedge clk);
      chk("to_ready_after", cmd_ready, 1'b1);

      // stuck ack: release phase times out, then stale ack completes the next request
      rmode = R_STUCK; cfg_ret = 1'b0; cfg_rd = 32'h0BAD_F00D;
      run_cmd(8'd9, 1'b1, 32'h0, lat, rh, o_ret, o_rd, o_to, ok);
      chk("stuck_done", ok, 1'b1);
      chk("stuck_flag", o_to, 1'b1);
      chk("stuck_ret", o_ret, 1'b1);
      chk("stuck_rdata", o_rd, 32'h0);
      run_cmd(8'd9, 1'b0, 32'h5, lat, rh, o_ret, o_rd, o_to, ok);
      chk("stale_done", ok, 1'b1);
      chk("stale_req_cycles", rh, 1);
      rmode = R_NORMAL; dly_dn = 1;
      repeat (6) @(negedge clk);

      // asynchronous reset while req is high
      rmode = R_SILENT;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_id = 8'h44; cmd_fn = 1'b0; cmd_wdata = 32'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (!req && w < 10) begin @(negedge clk); w++; end
      chk("rst_req_before", req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_req_async", req, 1'b0);
      chk("rst_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1'b1);
      rmode = R_NORMAL; dly_up = 2; dly_dn = 1; cfg_ret = 1'b0;
      run_cmd(8'h45, 1'b0, 32'h99, lat, rh, o_ret, o_rd, o_to, ok);
      chk("post_rst_done", ok, 1'b1);
      chk("post_rst_latency", lat, 8);
      chk("post_rst_timeout", o_to, 1'b0);

      // randomized traffic against the model
      for (int t = 0; t < 60; t++) begin
         int gap;
         int pick;
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         pick   = $urandom_range(0, 9);
         rmode  = R_NORMAL;
         dly_up = $urandom_range(1, 6);
         dly_dn = $urandom_range(1, 4);
         if (pick == 0) rmode = R_SILENT;
         else if (pick == 1) dly_up = $urandom_range(14, 20);
         else if (pick == 2) dly_dn = $urandom_range(14, 20);
         else if (pick == 3) rmode = R_STUCK;
         cfg_ret = 1'($urandom);
         cfg_rd  = $urandom;
         run_cmd(8'($urandom), 1'($urandom), $urandom, lat, rh, o_ret, o_rd, o_to, ok);
         chk("rand_done", ok, 1'b1);
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
